unified_cache_port_arbiter: RTL
===============================

// Module: unified_cache_port_arbiter
// PURPOSE
//  Shares the single request channel of the unified cache between the L1 inst and L1 data requesters.
//  Round-robin arbitration forwards one request packet at a time to the cache.
//  Cache responses are demultiplexed back to the owner by the packet's INST/DATA flag field.
//  Sits between the L1 fetch/LSU packet ports and the unified_cache inst/data-agnostic port.
// PARAMETERS
//  PKT_W        `UNIFIED_CACHE_PACKET_WIDTH_IN_BITS   packet width
//  VALID_POS    `UNIFIED_CACHE_PACKET_VALID_POS       valid bit index
//  FLAG_HI      `UNIFIED_CACHE_PACKET_FLAG_POS_HI     flag field MSB
//  FLAG_LO      `UNIFIED_CACHE_PACKET_FLAG_POS_LO     flag field LSB
//  MAX_STREAK   4                                      max consecutive grants to one side while the other waits
// PORTS
//  clk_in                  in   1      clock
//  reset_in                in   1      reset, asynchronous, active-high
//  inst_req_packet_in      in   PKT_W  inst request (held until ack)
//  inst_req_ack_out        out  1      1-cycle accept pulse to inst
//  data_req_packet_in      in   PKT_W  data request (held until ack)
//  data_req_ack_out        out  1      1-cycle accept pulse to data
//  to_cache_packet_out     out  PKT_W  registered request to cache
//  to_cache_ack_in         in   1      cache accepted request
//  from_cache_packet_in    in   PKT_W  cache response
//  from_cache_ack_out      out  1      1-cycle accept pulse to cache
//  inst_resp_packet_out    out  PKT_W  registered response to inst
//  inst_resp_ack_in        in   1      inst consumed response
//  data_resp_packet_out    out  PKT_W  registered response to data
//  data_resp_ack_in        in   1      data consumed response
//  bad_flag_out            out  1      sticky: response with unknown flag dropped
// BEHAVIOUR
//  Reset: all packet outputs 0, all acks 0, bad_flag_out 0, FSM IDLE, last_grant=DATA, streak=0.
//  Handshake: producer holds packet with valid=1; consumer pulses ack for exactly 1 cycle; acks registered.
//  Request FSM IDLE->HOLD:
//   - IDLE, edge t: pick among valid inputs; both valid -> side != last_grant, unless streak<MAX_STREAK
//     and last_grant side valid... no: strict alternation when both valid; streak counts grants to
//     one side with other valid; streak==MAX_STREAK forces other side (safety net, must never trigger
//     under alternation; assertion checks it).
//   - Same edge: latch packet into to_cache_packet_out, set chosen *_req_ack_out=1 for cycle t..t+1,
//     update last_grant, -> HOLD.
//  HOLD: hold to_cache_packet_out unchanged; on to_cache_ack_in=1 clear it to 0, -> IDLE.
//   to_cache_ack_in high for several cycles counts once; ack while IDLE ignored.
//  Min request cadence: one packet per 2 cycles (accept t, earliest cache ack t+1, IDLE t+2).
//  Response path (independent of request FSM):
//   - from_cache valid, flag==`INST_PACKET_FLAG and inst_resp empty -> copy, pulse from_cache_ack_out.
//   - flag==`DATA_PACKET_FLAG and data_resp empty -> same into data_resp.
//   - destination full -> no ack, wait (no reordering, no bypass).
//   - unknown flag -> ack and drop, set bad_flag_out (sticky until reset).
//   - blanking: after accept at edge t, from_cache_packet_in ignored at t+1 (source still valid).
//   - *_resp_ack_in=1 while that output valid -> clear to 0 next edge; ack on empty ignored.
//   - resp ack_in and new capture same edge for same side: impossible (blocked by "empty" rule).
//  Reset mid-transfer: everything cleared immediately; in-flight packets lost; upstream must replay.
// STRUCTURE
//  Flag values, positions, widths: `defines in parameters.h (shared with unified_cache).
//  One sub-module: packet_rr_arbiter2 (2-way round-robin, last_grant + streak counter, grant one-hot).
//  Top holds request FSM, response demux and all output registers.
// TESTING
//  1 inst only, addr 0x00,0x10,0x20 -> to_cache gets 3 packets in order, inst_req_ack 3 pulses, no data ack.
//  2 inst+data always valid, cache acks after 1 cycle -> grant order I,D,I,D..., streak never > 1.
//  3 cache holds to_cache_ack_in high 3 cycles -> exactly one packet consumed, no duplicate issue.
//  4 responses I(0x00) then D(0x40), inst_resp_ack withheld 20 cycles -> D delivered, I waits;
//    then 2nd I response stalls from_cache_ack until inst_resp freed.
//  5 response with undefined flag -> acked once, dropped, bad_flag_out=1, both resp outputs stay 0.
//  6 reset_in pulsed during HOLD with to_cache valid -> all outputs 0 asynchronously, next grant = inst.

Source files
------------

// File: rtl/unified_cache_port_arbiter_pkg.sv
// Shared packet layout, flag encodings and arbitration types for the
// unified cache port arbiter and its round-robin helper.
package unified_cache_port_arbiter_pkg;

   localparam int UC_PKT_W      = 40;
   localparam int UC_VALID_POS  = 39;
   localparam int UC_FLAG_HI    = 38;
   localparam int UC_FLAG_LO    = 37;
   localparam int UC_MAX_STREAK = 4;

   localparam logic [1:0] UC_INST_FLAG = 2'b01;
   localparam logic [1:0] UC_DATA_FLAG = 2'b10;

   typedef enum logic {
      REQ_IDLE = 1'b0,
      REQ_HOLD = 1'b1
   } req_state_e;

   typedef enum logic {
      SIDE_INST = 1'b0,
      SIDE_DATA = 1'b1
   } side_e;

   function automatic side_e other_side(input side_e s);
      return (s == SIDE_INST) ? SIDE_DATA : SIDE_INST;
   endfunction

   function automatic logic [1:0] side_onehot(input side_e s);
      return (s == SIDE_INST) ? 2'b01 : 2'b10;
   endfunction

endpackage

// File: rtl/unified_cache_port_arbiter_rr.sv
// packet_rr_arbiter2: two-way round-robin grant for the inst/data ports.
// Alternates under contention; the streak cap is a backstop that must stay idle.
module packet_rr_arbiter2
   import unified_cache_port_arbiter_pkg::*;
#(
   parameter int MAX_STREAK = UC_MAX_STREAK
) (
   input  logic       clk_in,
   input  logic       reset_in,
   input  logic [1:0] req_i,
   input  logic       grant_en_i,
   output logic [1:0] grant_o
);

   localparam int SW = $clog2(MAX_STREAK + 1);

   side_e         last_grant_q;
   side_e         last_grant_d;
   logic [SW-1:0] streak_q;
   logic [SW-1:0] streak_d;
   side_e         win;
   logic          contend;
   logic          streak_cap;

   always_comb begin
      contend    = &req_i;
      streak_cap = (streak_q >= SW'(MAX_STREAK));
      win        = SIDE_INST;
      grant_o    = '0;
      unique case (req_i)
         2'b11:   win = other_side(last_grant_q);
         2'b10:   win = SIDE_DATA;
         default: win = SIDE_INST;
      endcase
      if (contend && streak_cap) begin
         win = other_side(last_grant_q);
      end
      if (|req_i) begin
         grant_o = side_onehot(win);
      end
   end

   // streak only grows when one side wins again while the other is waiting
   always_comb begin
      last_grant_d = last_grant_q;
      streak_d     = streak_q;
      if (grant_en_i && (|req_i)) begin
         last_grant_d = win;
         if (!contend) begin
            streak_d = '0;
         end else if (win != last_grant_q) begin
            streak_d = SW'(1);
         end else if (!streak_cap) begin
            streak_d = streak_q + SW'(1);
         end
      end
   end

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         last_grant_q <= SIDE_DATA;
         streak_q     <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         streak_q     <= streak_d;
      end
   end

   a_streak_cap_idle : assert property (
      @(posedge clk_in) disable iff (reset_in) !streak_cap
   );

endmodule

// File: rtl/unified_cache_port_arbiter.sv
// Shares the unified cache request channel between L1 inst and L1 data and
// returns cache responses to their owner by the packet flag field.
module unified_cache_port_arbiter
   import unified_cache_port_arbiter_pkg::*;
#(
   parameter int PKT_W      = UC_PKT_W,
   parameter int VALID_POS  = UC_VALID_POS,
   parameter int FLAG_HI    = UC_FLAG_HI,
   parameter int FLAG_LO    = UC_FLAG_LO,
   parameter int MAX_STREAK = UC_MAX_STREAK,
   parameter logic [FLAG_HI-FLAG_LO:0] INST_FLAG = UC_INST_FLAG,
   parameter logic [FLAG_HI-FLAG_LO:0] DATA_FLAG = UC_DATA_FLAG
) (
   input  logic             clk_in,
   input  logic             reset_in,
   input  logic [PKT_W-1:0] inst_req_packet_in,
   output logic             inst_req_ack_out,
   input  logic [PKT_W-1:0] data_req_packet_in,
   output logic             data_req_ack_out,
   output logic [PKT_W-1:0] to_cache_packet_out,
   input  logic             to_cache_ack_in,
   input  logic [PKT_W-1:0] from_cache_packet_in,
   output logic             from_cache_ack_out,
   output logic [PKT_W-1:0] inst_resp_packet_out,
   input  logic             inst_resp_ack_in,
   output logic [PKT_W-1:0] data_resp_packet_out,
   input  logic             data_resp_ack_in,
   output logic             bad_flag_out
);

   localparam int FLAG_W = FLAG_HI - FLAG_LO + 1;

   req_state_e       state_q;
   req_state_e       state_d;
   logic [PKT_W-1:0] to_cache_q;
   logic [PKT_W-1:0] to_cache_d;
   logic             inst_req_ack_q;
   logic             inst_req_ack_d;
   logic             data_req_ack_q;
   logic             data_req_ack_d;
   logic [1:0]       req_v;
   logic [1:0]       grant;
   logic             grant_en;

   logic [PKT_W-1:0] inst_resp_q;
   logic [PKT_W-1:0] inst_resp_d;
   logic [PKT_W-1:0] data_resp_q;
   logic [PKT_W-1:0] data_resp_d;
   logic             from_cache_ack_q;
   logic             from_cache_ack_d;
   logic             bad_flag_q;
   logic             bad_flag_d;
   logic [FLAG_W-1:0] resp_flag;
   logic             resp_v;
   logic             is_inst;
   logic             is_data;

   assign req_v = {data_req_packet_in[VALID_POS],
                   inst_req_packet_in[VALID_POS]};

   packet_rr_arbiter2 #(
      .MAX_STREAK (MAX_STREAK)
   ) u_rr (
      .clk_in     (clk_in),
      .reset_in   (reset_in),
      .req_i      (req_v),
      .grant_en_i (grant_en),
      .grant_o    (grant)
   );

   always_comb begin
      state_d        = state_q;
      to_cache_d     = to_cache_q;
      inst_req_ack_d = 1'b0;
      data_req_ack_d = 1'b0;
      grant_en       = 1'b0;
      unique case (state_q)
         REQ_IDLE: begin
            if (|req_v) begin
               grant_en       = 1'b1;
               to_cache_d     = grant[0] ? inst_req_packet_in
                                         : data_req_packet_in;
               inst_req_ack_d = grant[0];
               data_req_ack_d = grant[1];
               state_d        = REQ_HOLD;
            end
         end
         REQ_HOLD: begin
            if (to_cache_ack_in) begin
               to_cache_d = '0;
               state_d    = REQ_IDLE;
            end
         end
         default: state_d = REQ_IDLE;
      endcase
   end

   // the cycle after our accept the source still shows the old packet
   assign resp_flag = from_cache_packet_in[FLAG_HI:FLAG_LO];
   assign resp_v    = from_cache_packet_in[VALID_POS] && !from_cache_ack_q;
   assign is_inst   = (resp_flag == INST_FLAG);
   assign is_data   = (resp_flag == DATA_FLAG);

   always_comb begin
      inst_resp_d      = inst_resp_q;
      data_resp_d      = data_resp_q;
      from_cache_ack_d = 1'b0;
      bad_flag_d       = bad_flag_q;
      if (inst_resp_ack_in && inst_resp_q[VALID_POS]) begin
         inst_resp_d = '0;
      end
      if (data_resp_ack_in && data_resp_q[VALID_POS]) begin
         data_resp_d = '0;
      end
      if (resp_v) begin
         unique case (1'b1)
            is_inst: begin
               if (!inst_resp_q[VALID_POS]) begin
                  inst_resp_d      = from_cache_packet_in;
                  from_cache_ack_d = 1'b1;
               end
            end
            is_data: begin
               if (!data_resp_q[VALID_POS]) begin
                  data_resp_d      = from_cache_packet_in;
                  from_cache_ack_d = 1'b1;
               end
            end
            default: begin
               from_cache_ack_d = 1'b1;
               bad_flag_d       = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         state_q          <= REQ_IDLE;
         to_cache_q       <= '0;
         inst_req_ack_q   <= 1'b0;
         data_req_ack_q   <= 1'b0;
         inst_resp_q      <= '0;
         data_resp_q      <= '0;
         from_cache_ack_q <= 1'b0;
         bad_flag_q       <= 1'b0;
      end else begin
         state_q          <= state_d;
         to_cache_q       <= to_cache_d;
         inst_req_ack_q   <= inst_req_ack_d;
         data_req_ack_q   <= data_req_ack_d;
         inst_resp_q      <= inst_resp_d;
         data_resp_q      <= data_resp_d;
         from_cache_ack_q <= from_cache_ack_d;
         bad_flag_q       <= bad_flag_d;
      end
   end

   assign to_cache_packet_out  = to_cache_q;
   assign inst_req_ack_out     = inst_req_ack_q;
   assign data_req_ack_out     = data_req_ack_q;
   assign inst_resp_packet_out = inst_resp_q;
   assign data_resp_packet_out = data_resp_q;
   assign from_cache_ack_out   = from_cache_ack_q;
   assign bad_flag_out         = bad_flag_q;

   a_req_ack_onehot : assert property (
      @(posedge clk_in) disable iff (reset_in)
      !(inst_req_ack_q && data_req_ack_q)
   );

   a_hold_stable : assert property (
      @(posedge clk_in) disable iff (reset_in)
      (state_q == REQ_HOLD && !to_cache_ack_in) |=> $stable(to_cache_q)
   );

endmodule
